// File: rtl/lfsr_pkg.sv
// Shared types and maximal-length polynomial constants for the LFSR random source.
package lfsr_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        DONE = 2'd2
    } fsm_state_t;

    // Galois right-shift masks: bit (k-1) set for each feedback tap x^k
    localparam logic [12:0] LFSR13_TAPS = 13'h100D;
    localparam logic [12:0] LFSR13_SEED = 13'h0ACE;
    localparam logic [15:0] LFSR16_TAPS = 16'hB400;
    localparam logic [15:0] LFSR16_SEED = 16'hACE1;
    localparam logic [31:0] LFSR32_TAPS = 32'h8020_0003;
    localparam logic [31:0] LFSR32_SEED = 32'hACE1_ACE1;

endpackage

// File: rtl/lfsr_core.sv
// Free-running Galois LFSR with seed load, zero-seed substitution and lockup recovery.
module lfsr_core
    import lfsr_pkg::*;
#(
    parameter int               WIDTH = 16,
    parameter logic [WIDTH-1:0] TAPS  = LFSR16_TAPS,
    parameter logic [WIDTH-1:0] SEED  = LFSR16_SEED
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             seed_we,
    input  logic [WIDTH-1:0] seed_in,
    output logic [WIDTH-1:0] state
);

    logic [WIDTH-1:0] stepped;
    logic [WIDTH-1:0] state_next;

    always_comb begin
        stepped    = (state >> 1) ^ (state[0] ? TAPS : '0);
        state_next = state;
        if (seed_we) begin
            state_next = (seed_in == '0) ? SEED : seed_in;
        end else if (state == '0) begin
            // an all-zero register would never leave zero on its own
            state_next = SEED;
        end else if (en) begin
            state_next = stepped;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= SEED;
        end else begin
            state <= state_next;
        end
    end

endmodule

// File: rtl/lfsr_rand_range.sv
// Bounded random value generator: rand_out = min_val + (lfsr sample mod span),
// computed by a bit-serial restoring divider and held under a valid/ack handshake.
module lfsr_rand_range
    import lfsr_pkg::*;
#(
    parameter int               WIDTH = 16,
    parameter logic [WIDTH-1:0] TAPS  = LFSR16_TAPS,
    parameter logic [WIDTH-1:0] SEED  = LFSR16_SEED
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             seed_we,
    input  logic [WIDTH-1:0] seed_in,
    input  logic             req,
    input  logic [WIDTH-1:0] span,
    input  logic [WIDTH-1:0] min_val,
    input  logic             ack,
    output logic             busy,
    output logic             valid,
    output logic [WIDTH-1:0] rand_out,
    output logic             span_err,
    output logic [WIDTH-1:0] lfsr_state
);

    localparam int CW = $clog2(WIDTH + 1);

    fsm_state_t       state;
    fsm_state_t       state_next;
    logic [WIDTH-1:0] sample;
    logic [WIDTH-1:0] span_q;
    logic [WIDTH-1:0] min_q;
    logic [WIDTH-1:0] rem;
    logic [WIDTH:0]   rem_shift;
    logic [WIDTH:0]   rem_diff;
    logic [WIDTH-1:0] rem_next;
    logic [CW-1:0]    bit_cnt;
    logic             last_bit;

    lfsr_core #(
        .WIDTH (WIDTH),
        .TAPS  (TAPS),
        .SEED  (SEED)
    ) u_lfsr_core (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .seed_we (seed_we),
        .seed_in (seed_in),
        .state   (lfsr_state)
    );

    // rem < span always holds, so only the shifted trial value needs the extra bit;
    // the borrow of the trial subtraction doubles as the rem >= span compare
    always_comb begin
        rem_shift = {rem, sample[WIDTH-1]};
        rem_diff  = rem_shift - {1'b0, span_q};
        rem_next  = rem_diff[WIDTH] ? rem_shift[WIDTH-1:0] : rem_diff[WIDTH-1:0];
        last_bit  = (bit_cnt == CW'(1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (req) state_next = (span == '0) ? DONE : DIV;
            DIV:     if (last_bit) state_next = DONE;
            DONE:    if (ack) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy  = (state != IDLE);
        valid = (state == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sample   <= '0;
            span_q   <= '0;
            min_q    <= '0;
            rem      <= '0;
            bit_cnt  <= '0;
            rand_out <= '0;
            span_err <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        sample  <= lfsr_state;
                        span_q  <= span;
                        min_q   <= min_val;
                        rem     <= '0;
                        bit_cnt <= CW'(WIDTH);
                        if (span == '0) begin
                            rand_out <= min_val;
                            span_err <= 1'b1;
                        end
                    end
                end
                DIV: begin
                    sample  <= sample << 1;
                    rem     <= rem_next;
                    bit_cnt <= bit_cnt - CW'(1);
                    if (last_bit) begin
                        rand_out <= min_q + rem_next;
                        span_err <= 1'b0;
                    end
                end
                DONE: begin
                    if (ack) span_err <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_lfsr_rand_range.sv
// Self-checking bench for lfsr_rand_range: directed scenarios plus randomized
// requests checked against a plain-arithmetic reference model.
module tb_lfsr_rand_range;

    localparam logic [15:0] TAPS = 16'hB400;
    localparam logic [15:0] SEED = 16'hACE1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        en = 1'b0;
    logic        seed_we = 1'b0;
    logic [15:0] seed_in = 16'h0;
    logic        req = 1'b0;
    logic [15:0] span = 16'h0;
    logic [15:0] min_val = 16'h0;
    logic        ack = 1'b0;
    logic        busy;
    logic        valid;
    logic [15:0] rand_out;
    logic        span_err;
    logic [15:0] lfsr_state;

    int n_pass = 0;
    int n_total = 0;
    logic [15:0] m_lfsr;

    always #5 clk = ~clk;

    lfsr_rand_range #(
        .WIDTH (16),
        .TAPS  (TAPS),
        .SEED  (SEED)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .seed_we    (seed_we),
        .seed_in    (seed_in),
        .req        (req),
        .span       (span),
        .min_val    (min_val),
        .ack        (ack),
        .busy       (busy),
        .valid      (valid),
        .rand_out   (rand_out),
        .span_err   (span_err),
        .lfsr_state (lfsr_state)
    );

    // reference LFSR: integer halving and parity instead of bit slicing
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m_lfsr <= SEED;
        else if (seed_we) m_lfsr <= (seed_in == 16'h0) ? SEED : seed_in;
        else if (m_lfsr == 16'h0) m_lfsr <= SEED;
        else if (en) m_lfsr <= (m_lfsr / 16'd2) ^ (((m_lfsr % 16'd2) == 16'd1) ? TAPS : 16'h0);
    end

    function automatic logic [15:0] ref_result(input logic [15:0] s, input logic [15:0] sp,
                                               input logic [15:0] mn);
        int unsigned a;
        int unsigned b;
        int unsigned c;
        int unsigned r;
        a = s;
        b = sp;
        c = mn;
        if (b == 0) return mn;
        r = (c + (a % b)) % 65536;
        return r[15:0];
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic run_request(input logic [15:0] sp, input logic [15:0] mn,
                               output logic [15:0] smp, output int edges);
        smp = m_lfsr;
        req = 1'b1;
        span = sp;
        min_val = mn;
        tick();
        req = 1'b0;
        span = 16'($urandom);
        min_val = 16'($urandom);
        edges = 1;
        while (!valid && edges < 40) begin
            tick();
            edges++;
        end
    endtask

    task automatic do_ack();
        ack = 1'b1;
        tick();
        ack = 1'b0;
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        tick();
        n_total++; if (lfsr_state !== SEED) $display("FAIL reset_lfsr got %h want %h", lfsr_state, SEED); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else n_pass++;
        n_total++; if (valid !== 1'b0) $display("FAIL reset_valid got %b want 0", valid); else n_pass++;
        n_total++; if (rand_out !== 16'h0) $display("FAIL reset_rand got %h want 0000", rand_out); else n_pass++;
        n_total++; if (span_err !== 1'b0) $display("FAIL reset_span_err got %b want 0", span_err); else n_pass++;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_lfsr_step();
        n_total++; if (lfsr_state !== 16'hACE1) $display("FAIL step0 got %h want ace1", lfsr_state); else n_pass++;
        en = 1'b1;
        tick();
        n_total++; if (lfsr_state !== 16'hE270) $display("FAIL step1 got %h want e270", lfsr_state); else n_pass++;
        tick();
        n_total++; if (lfsr_state !== 16'h7138) $display("FAIL step2 got %h want 7138", lfsr_state); else n_pass++;
        en = 1'b0;
        repeat (3) tick();
        n_total++; if (lfsr_state !== 16'h7138) $display("FAIL hold got %h want 7138", lfsr_state); else n_pass++;
    endtask

    task automatic test_seed_load();
        seed_we = 1'b1;
        seed_in = 16'h1234;
        tick();
        n_total++; if (lfsr_state !== 16'h1234) $display("FAIL seed_load got %h want 1234", lfsr_state); else n_pass++;
        seed_in = 16'h0;
        tick();
        n_total++; if (lfsr_state !== SEED) $display("FAIL seed_zero got %h want %h", lfsr_state, SEED); else n_pass++;
        en = 1'b1;
        seed_in = 16'h5555;
        tick();
        n_total++; if (lfsr_state !== 16'h5555) $display("FAIL seed_over_en got %h want 5555", lfsr_state); else n_pass++;
        seed_we = 1'b0;
        tick();
        n_total++; if (lfsr_state !== m_lfsr) $display("FAIL step_after_seed got %h want %h", lfsr_state, m_lfsr); else n_pass++;
        en = 1'b0;
    endtask

    task automatic test_basic_request();
        int  edges;
        logic stable;
        seed_we = 1'b1;
        seed_in = 16'h0;
        tick();
        seed_we = 1'b0;
        req = 1'b1;
        span = 16'd100;
        min_val = 16'd500;
        tick();
        req = 1'b0;
        span = 16'h7777;
        min_val = 16'h0;
        n_total++; if (busy !== 1'b1 || valid !== 1'b0) $display("FAIL basic_busy got busy=%b valid=%b want 1/0", busy, valid); else n_pass++;
        edges = 1;
        while (!valid && edges < 40) begin
            tick();
            edges++;
        end
        n_total++; if (edges != 17) $display("FAIL basic_latency got %0d want 17", edges); else n_pass++;
        n_total++; if (rand_out !== 16'h022D) $display("FAIL basic_rand got %h want 022d", rand_out); else n_pass++;
        n_total++; if (span_err !== 1'b0) $display("FAIL basic_span_err got %b want 0", span_err); else n_pass++;
        stable = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (valid !== 1'b1 || rand_out !== 16'h022D) stable = 1'b0;
        end
        n_total++; if (stable !== 1'b1) $display("FAIL basic_hold got valid=%b rand=%h want 1/022d", valid, rand_out); else n_pass++;
        do_ack();
        n_total++; if (valid !== 1'b0 || busy !== 1'b0) $display("FAIL basic_ack got valid=%b busy=%b want 0/0", valid, busy); else n_pass++;
        n_total++; if (rand_out !== 16'h022D) $display("FAIL basic_rand_kept got %h want 022d", rand_out); else n_pass++;
    endtask

    task automatic test_span_edges();
        int edges;
        logic [15:0] smp;
        run_request(16'd0, 16'h0042, smp, edges);
        n_total++; if (edges != 1) $display("FAIL span0_latency got %0d want 1", edges); else n_pass++;
        n_total++; if (rand_out !== 16'h0042) $display("FAIL span0_rand got %h want 0042", rand_out); else n_pass++;
        n_total++; if (span_err !== 1'b1) $display("FAIL span0_err got %b want 1", span_err); else n_pass++;
        do_ack();
        n_total++; if (span_err !== 1'b0 || valid !== 1'b0) $display("FAIL span0_ack got err=%b valid=%b want 0/0", span_err, valid); else n_pass++;
        run_request(16'd1, 16'h1234, smp, edges);
        n_total++; if (edges != 17) $display("FAIL span1_latency got %0d want 17", edges); else n_pass++;
        n_total++; if (rand_out !== 16'h1234 || span_err !== 1'b0) $display("FAIL span1_rand got %h err=%b want 1234/0", rand_out, span_err); else n_pass++;
        do_ack();
        run_request(16'd100, 16'hFFFF, smp, edges);
        n_total++; if (rand_out !== 16'h0038) $display("FAIL wrap_rand got %h want 0038 (sample %h)", rand_out, smp); else n_pass++;
        do_ack();
    endtask

    task automatic test_ignored_req();
        int edges;
        logic [15:0] smp;
        logic [15:0] smp2;
        logic [15:0] sp;
        logic [15:0] mn;
        logic [15:0] exp_v;
        en = 1'b1;
        sp = 16'($urandom_range(2, 60000));
        mn = 16'($urandom);
        smp = m_lfsr;
        req = 1'b1;
        span = sp;
        min_val = mn;
        tick();
        edges = 1;
        while (!valid && edges < 40) begin
            req = ((edges % 3) == 0);
            span = 16'($urandom);
            min_val = 16'($urandom);
            tick();
            edges++;
        end
        exp_v = ref_result(smp, sp, mn);
        n_total++; if (edges != 17) $display("FAIL ign_latency got %0d want 17", edges); else n_pass++;
        n_total++; if (rand_out !== exp_v) $display("FAIL ign_rand got %h want %h", rand_out, exp_v); else n_pass++;
        req = 1'b1;
        span = 16'd0;
        repeat (2) tick();
        n_total++; if (valid !== 1'b1 || rand_out !== exp_v || span_err !== 1'b0) $display("FAIL ign_done got valid=%b rand=%h err=%b want 1/%h/0", valid, rand_out, span_err, exp_v); else n_pass++;
        sp = 16'($urandom_range(2, 1000));
        mn = 16'($urandom);
        span = sp;
        min_val = mn;
        ack = 1'b1;
        tick();
        ack = 1'b0;
        n_total++; if (busy !== 1'b0 || valid !== 1'b0) $display("FAIL ign_ack_cycle got busy=%b valid=%b want 0/0", busy, valid); else n_pass++;
        smp2 = m_lfsr;
        tick();
        req = 1'b0;
        n_total++; if (busy !== 1'b1) $display("FAIL req_after_ack got busy=%b want 1", busy); else n_pass++;
        edges = 1;
        while (!valid && edges < 40) begin
            tick();
            edges++;
        end
        exp_v = ref_result(smp2, sp, mn);
        n_total++; if (edges != 17 || rand_out !== exp_v) $display("FAIL req_after_ack_rand got %h after %0d want %h after 17", rand_out, edges, exp_v); else n_pass++;
        do_ack();
        en = 1'b0;
    endtask

    task automatic test_reset_mid_div();
        int edges;
        logic [15:0] smp;
        logic [15:0] sp;
        logic [15:0] mn;
        logic seen;
        en = 1'b1;
        req = 1'b1;
        span = 16'd100;
        min_val = 16'd7;
        tick();
        req = 1'b0;
        repeat (8) tick();
        rst_n = 1'b0;
        #1;
        n_total++; if (busy !== 1'b0 || valid !== 1'b0) $display("FAIL midrst_clear got busy=%b valid=%b want 0/0", busy, valid); else n_pass++;
        n_total++; if (lfsr_state !== SEED) $display("FAIL midrst_lfsr got %h want %h", lfsr_state, SEED); else n_pass++;
        tick();
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 25; i++) begin
            tick();
            if (valid !== 1'b0 || busy !== 1'b0) seen = 1'b1;
        end
        n_total++; if (seen !== 1'b0) $display("FAIL midrst_no_result got seen=%b want 0", seen); else n_pass++;
        sp = 16'($urandom_range(1, 65535));
        mn = 16'($urandom);
        run_request(sp, mn, smp, edges);
        n_total++; if (edges != 17 || rand_out !== ref_result(smp, sp, mn)) $display("FAIL midrst_after got %h after %0d want %h after 17", rand_out, edges, ref_result(smp, sp, mn)); else n_pass++;
        do_ack();
        en = 1'b0;
    endtask

    task automatic test_random();
        int edges;
        logic [15:0] smp;
        logic [15:0] sp;
        logic [15:0] mn;
        logic [15:0] exp_v;
        for (int i = 0; i < 24; i++) begin
            en = 1'($urandom);
            if ((i % 4) == 0) begin
                seed_we = 1'b1;
                seed_in = ((i % 8) == 0) ? 16'h0 : 16'($urandom);
                tick();
                seed_we = 1'b0;
                n_total++; if (lfsr_state !== m_lfsr) $display("FAIL rnd_seed[%0d] got %h want %h", i, lfsr_state, m_lfsr); else n_pass++;
            end
            case ($urandom_range(0, 3))
                0:       sp = 16'h0;
                1:       sp = 16'($urandom_range(1, 7));
                2:       sp = 16'hFFFF;
                default: sp = 16'($urandom);
            endcase
            mn = 16'($urandom);
            run_request(sp, mn, smp, edges);
            exp_v = ref_result(smp, sp, mn);
            n_total++; if (edges != ((sp == 16'h0) ? 1 : 17)) $display("FAIL rnd_latency[%0d] got %0d span=%h", i, edges, sp); else n_pass++;
            n_total++; if (rand_out !== exp_v) $display("FAIL rnd_rand[%0d] got %h want %h (s=%h sp=%h mn=%h)", i, rand_out, exp_v, smp, sp, mn); else n_pass++;
            n_total++; if (span_err !== (sp == 16'h0)) $display("FAIL rnd_err[%0d] got %b want %b", i, span_err, (sp == 16'h0)); else n_pass++;
            repeat ($urandom_range(0, 3)) tick();
            do_ack();
            n_total++; if (valid !== 1'b0) $display("FAIL rnd_ack[%0d] got valid=%b want 0", i, valid); else n_pass++;
        end
        en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_lfsr_step();
        test_seed_load();
        test_basic_request();
        test_span_edges();
        test_ignored_req();
        test_reset_mid_div();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired after %0d of %0d checks", n_pass, n_total);
        $fatal(1);
    end

endmodule
